// File: rtl/decode_queue.sv
// decode_queue: RV32 instruction decoder feeding a small FIFO of decoded entries.
// Each instruction is decoded combinationally as it arrives. The decoded result is
// written into the tail entry on a push. The head entry drives the outputs directly
// from storage.
//
// Ports:
//   clk, reset              clock (rising edge), synchronous active-high reset
//   flush                   drop every queued entry (redirect)
//   in_valid/in_ready       fetch handshake; in_instruction, in_pc are the payload
//   out_valid/out_ready     execute handshake for the head entry
//   out_*                   head entry fields, enables and illegal flag
//   count                   number of occupied entries
//
// Type codes: R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
module decode_queue #(
    parameter int DEPTH      = 4,
    parameter int ENABLE_FP  = 1,
    parameter int ENABLE_CSR = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instruction,
    input  logic [31:0]                in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [6:0]                 out_opcode,
    output logic [2:0]                 out_funct3,
    output logic [6:0]                 out_funct7,
    output logic [11:0]                out_funct12,
    output logic [4:0]                 out_read_index_1,
    output logic [4:0]                 out_read_index_2,
    output logic [4:0]                 out_write_index,
    output logic [11:0]                out_csr_index,
    output logic [2:0]                 out_instruction_type,
    output logic                       out_read_enable_1,
    output logic                       out_read_enable_2,
    output logic                       out_write_enable,
    output logic                       out_read_enable_csr,
    output logic                       out_write_enable_csr,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [2:0] TYPE_R   = 3'd0;
    localparam logic [2:0] TYPE_I   = 3'd1;
    localparam logic [2:0] TYPE_S   = 3'd2;
    localparam logic [2:0] TYPE_B   = 3'd3;
    localparam logic [2:0] TYPE_U   = 3'd4;
    localparam logic [2:0] TYPE_J   = 3'd5;
    localparam logic [2:0] TYPE_ILL = 3'd7;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  itype;
        logic        re1;
        logic        re2;
        logic        we;
        logic        re_csr;
        logic        we_csr;
        logic        ill;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          dec;
    entry_t          head_e;
    logic [PW-1:0]   head_ptr;
    logic [PW-1:0]   tail_ptr;
    logic            push;
    logic            pop;

    // Decode of the incoming instruction
    always_comb begin
        logic [6:0] op;
        logic [2:0] f3;
        logic       known;
        logic       is_fp;
        logic       is_sys;
        logic       is_csr;
        logic       ill;
        logic [2:0] itype;
        logic       re1, re2, we, rcsr, wcsr;

        op     = in_instruction[6:0];
        f3     = in_instruction[14:12];
        known  = 1'b1;
        is_fp  = 1'b0;
        is_sys = 1'b0;
        itype  = TYPE_ILL;
        case (op)
            7'b0110011: itype = TYPE_R;
            7'b1010011: begin itype = TYPE_R; is_fp = 1'b1; end
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: itype = TYPE_I;
            7'b0000111: begin itype = TYPE_I; is_fp = 1'b1; end
            7'b1110011: begin itype = TYPE_I; is_sys = 1'b1; end
            7'b0100011: itype = TYPE_S;
            7'b0100111: begin itype = TYPE_S; is_fp = 1'b1; end
            7'b1100011: itype = TYPE_B;
            7'b0010111, 7'b0110111: itype = TYPE_U;
            7'b1101111: itype = TYPE_J;
            default: known = 1'b0;
        endcase

        // funct3 000 is ECALL/EBREAK/xRET, 100 is reserved; everything else is Zicsr
        is_csr = is_sys && (f3 != 3'b000) && (f3 != 3'b100);

        ill = !known
            || (in_instruction[1:0] != 2'b11)
            || (is_fp && (ENABLE_FP == 0))
            || (is_sys && (f3 == 3'b100))
            || (is_csr && (ENABLE_CSR == 0));

        re1 = 1'b0;
        re2 = 1'b0;
        we  = 1'b0;
        case (itype)
            TYPE_R: begin re1 = 1'b1; re2 = 1'b1; we = 1'b1; end
            TYPE_I: begin re1 = 1'b1; we = 1'b1; end
            TYPE_S, TYPE_B: begin re1 = 1'b1; re2 = 1'b1; end
            TYPE_U, TYPE_J: we = 1'b1;
            default: ;
        endcase
        if (in_instruction[11:7] == 5'd0)
            we = 1'b0;

        // CSRRW/CSRRWI with rd=0 skip the read; set/clear with a zero source skip the write.
        // Read-only CSR space (csr[11:10]=11) never gets a write.
        rcsr = is_csr && !(((f3 == 3'b001) || (f3 == 3'b101)) && (in_instruction[11:7] == 5'd0));
        wcsr = is_csr
            && !((f3 != 3'b001) && (f3 != 3'b101) && (in_instruction[19:15] == 5'd0))
            && !(in_instruction[31:30] == 2'b11);

        dec        = '0;
        dec.pc     = in_pc;
        dec.instr  = in_instruction;
        dec.ill    = ill;
        dec.itype  = ill ? TYPE_ILL : itype;
        dec.re1    = re1 && !ill;
        dec.re2    = re2 && !ill;
        dec.we     = we && !ill;
        dec.re_csr = rcsr && !ill;
        dec.we_csr = wcsr && !ill;
    end

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push)
                tail_ptr <= tail_ptr + 1'b1;
            if (pop)
                head_ptr <= head_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[tail_ptr] <= dec;
    end

    assign head_e               = mem[head_ptr];
    assign out_pc               = head_e.pc;
    assign out_opcode           = head_e.instr[6:0];
    assign out_funct3           = head_e.instr[14:12];
    assign out_funct7           = head_e.instr[31:25];
    assign out_funct12          = head_e.instr[31:20];
    assign out_read_index_1     = head_e.instr[19:15];
    assign out_read_index_2     = head_e.instr[24:20];
    assign out_write_index      = head_e.instr[11:7];
    assign out_csr_index        = head_e.instr[31:20];
    assign out_instruction_type = head_e.itype;
    assign out_read_enable_1    = head_e.re1;
    assign out_read_enable_2    = head_e.re2;
    assign out_write_enable     = head_e.we;
    assign out_read_enable_csr  = head_e.re_csr;
    assign out_write_enable_csr = head_e.we_csr;
    assign out_illegal          = head_e.ill;

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instruction = '0;
    logic [31:0] in_pc = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3, out_instruction_type;
    logic [11:0] out_funct12, out_csr_index;
    logic [4:0]  out_read_index_1, out_read_index_2, out_write_index;
    logic        out_read_enable_1, out_read_enable_2, out_write_enable;
    logic        out_read_enable_csr, out_write_enable_csr, out_illegal;
    logic [2:0]  count;

    // Second instance with FP and CSR disabled, fed by the same stimulus
    logic        n_in_ready, n_out_valid;
    logic [31:0] n_out_pc;
    logic [6:0]  n_out_opcode, n_out_funct7;
    logic [2:0]  n_out_funct3, n_out_instruction_type;
    logic [11:0] n_out_funct12, n_out_csr_index;
    logic [4:0]  n_out_read_index_1, n_out_read_index_2, n_out_write_index;
    logic        n_out_read_enable_1, n_out_read_enable_2, n_out_write_enable;
    logic        n_out_read_enable_csr, n_out_write_enable_csr, n_out_illegal;
    logic [2:0]  n_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(4), .ENABLE_FP(1), .ENABLE_CSR(1)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_funct12(out_funct12), .out_read_index_1(out_read_index_1),
        .out_read_index_2(out_read_index_2), .out_write_index(out_write_index),
        .out_csr_index(out_csr_index), .out_instruction_type(out_instruction_type),
        .out_read_enable_1(out_read_enable_1), .out_read_enable_2(out_read_enable_2),
        .out_write_enable(out_write_enable), .out_read_enable_csr(out_read_enable_csr),
        .out_write_enable_csr(out_write_enable_csr), .out_illegal(out_illegal),
        .count(count)
    );

    decode_queue #(.DEPTH(4), .ENABLE_FP(0), .ENABLE_CSR(0)) u_dut_nofeat (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc),
        .out_opcode(n_out_opcode), .out_funct3(n_out_funct3), .out_funct7(n_out_funct7),
        .out_funct12(n_out_funct12), .out_read_index_1(n_out_read_index_1),
        .out_read_index_2(n_out_read_index_2), .out_write_index(n_out_write_index),
        .out_csr_index(n_out_csr_index), .out_instruction_type(n_out_instruction_type),
        .out_read_enable_1(n_out_read_enable_1), .out_read_enable_2(n_out_read_enable_2),
        .out_write_enable(n_out_write_enable), .out_read_enable_csr(n_out_read_enable_csr),
        .out_write_enable_csr(n_out_write_enable_csr), .out_illegal(n_out_illegal),
        .count(n_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one instruction into an empty queue; afterwards it is the head entry
    task automatic push_one(input logic [31:0] ins, input logic [31:0] pc);
        in_valid       = 1'b1;
        in_instruction = ins;
        in_pc          = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drop_head();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // {type, re1, re2, we, re_csr, we_csr, illegal}
    function automatic logic [8:0] ctl();
        return {out_instruction_type, out_read_enable_1, out_read_enable_2, out_write_enable,
                out_read_enable_csr, out_write_enable_csr, out_illegal};
    endfunction

    logic [31:0] exp_q[$];
    logic [31:0] next_pc;

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);

        // addi x1,x0,10
        push_one(32'h00A00093, 32'h0000_1000);
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_ctl", 32'(ctl()), 32'({3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        chk("addi_rd", 32'(out_write_index), 32'd1);
        chk("addi_pc", out_pc, 32'h0000_1000);
        chk("addi_count", 32'(count), 32'd1);
        drop_head();
        chk("drop_count", 32'(count), 32'd0);

        // add x0,x0,x0: R type but rd=0
        push_one(32'h00000033, 32'h0000_1004);
        chk("add_x0_ctl", 32'(ctl()), 32'({3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
        drop_head();

        // mret
        push_one(32'h30200073, 32'h0000_1008);
        chk("mret_ctl", 32'(ctl()), 32'({3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        chk("mret_funct12", 32'(out_funct12), 32'h302);
        chk("mret_nofeat_ill", 32'(n_out_illegal), 32'd0);
        drop_head();

        // csrrw x0,mscratch,x0
        push_one(32'h34001073, 32'h0000_100C);
        chk("csrrw_ctl", 32'(ctl()), 32'({3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
        chk("csrrw_index", 32'(out_csr_index), 32'h340);
        chk("csrrw_nocsr_ill", 32'(n_out_illegal), 32'd1);
        chk("csrrw_nocsr_type", 32'(n_out_instruction_type), 32'd7);
        drop_head();

        // csrrs x0,cycle,x0
        push_one(32'hC0002073, 32'h0000_1010);
        chk("csrrs_ctl", 32'(ctl()), 32'({3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
        drop_head();

        // csrrw x5,mscratch,x6: full read and write
        push_one(32'h340312F3, 32'h0000_1014);
        chk("csrrw_x5_ctl", 32'(ctl()), 32'({3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}));
        drop_head();

        // all-ones and all-zeros are illegal
        push_one(32'hFFFFFFFF, 32'h0000_1018);
        chk("ones_ctl", 32'(ctl()), 32'({3'd7, 5'b0, 1'b1}));
        drop_head();
        push_one(32'h00000000, 32'h0000_101C);
        chk("zeros_ctl", 32'(ctl()), 32'({3'd7, 5'b0, 1'b1}));
        drop_head();

        // SYSTEM funct3=100 is reserved
        push_one(32'h00004073, 32'h0000_1020);
        chk("sys100_ill", 32'(out_illegal), 32'd1);
        drop_head();

        // fadd.s f1,f2,f3: legal R with FP, illegal without
        push_one(32'h003100D3, 32'h0000_1024);
        chk("fadd_ctl", 32'(ctl()), 32'({3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
        chk("fadd_nofp_ill", 32'(n_out_illegal), 32'd1);
        drop_head();

        // sw x2,0(x1); beq; lui x3; jal x1
        push_one(32'h0020A023, 32'h0000_1028);
        chk("sw_ctl", 32'(ctl()), 32'({3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
        drop_head();
        push_one(32'h00208463, 32'h0000_102C);
        chk("beq_ctl", 32'(ctl()), 32'({3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
        drop_head();
        push_one(32'h000011B7, 32'h0000_1030);
        chk("lui_ctl", 32'(ctl()), 32'({3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        drop_head();
        push_one(32'h008000EF, 32'h0000_1034);
        chk("jal_ctl", 32'(ctl()), 32'({3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        drop_head();

        // Fill with out_ready low
        next_pc = 32'h0000_2000;
        for (int i = 0; i < 4; i++) begin
            push_one(32'h00A00093, next_pc);
            exp_q.push_back(next_pc);
            next_pc += 32'd4;
            chk("fill_count", 32'(count), 32'(i + 1));
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head_pc", out_pc, 32'h0000_2000);

        // Offer and consume every cycle; the queue drains to 3 then holds across wraps
        for (int i = 0; i < 12; i++) begin
            bit do_push;
            bit do_pop;
            in_valid       = 1'b1;
            in_instruction = 32'h00A00093;
            in_pc          = next_pc;
            out_ready      = 1'b1;
            chk("stream_in_ready", 32'(in_ready), 32'(exp_q.size() < 4));
            chk("stream_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0)
                chk("stream_pc", out_pc, exp_q[0]);
            do_push = (exp_q.size() < 4);
            do_pop  = (exp_q.size() != 0);
            tick();
            if (do_pop)
                void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back(next_pc);
                next_pc += 32'd4;
            end
            chk("stream_count", 32'(count), 32'(exp_q.size()));
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pre_flush_count", 32'(count), 32'd3);

        // Flush wins over a same-cycle push and pop
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);

        // Pointers restart at zero after flush; head must be the new entry
        push_one(32'h00500113, 32'h0000_3000);
        chk("post_flush_pc", out_pc, 32'h0000_3000);
        chk("post_flush_rd", 32'(out_write_index), 32'd2);
        push_one(32'h00000033, 32'h0000_3004);
        chk("pre_reset_count", 32'(count), 32'd2);

        // Reset beats a same-cycle push
        reset    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 32'h0000_4000;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_valid", 32'(out_valid), 32'd0);

        push_one(32'h00A00093, 32'h0000_5000);
        chk("post_reset_pc", out_pc, 32'h0000_5000);
        chk("post_reset_count", 32'(count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
